// File: rtl/pc_sender.sv
// Streams NUM_BYTES bytes from BRAM out of an 8N1 UART on entry into SEND_TO_PC.
// Define PC_SENDER_HEADER_EN to send the 0xA5, 0x5A header ahead of each transfer.
module pc_sender #(
    parameter int unsigned CLKS_PER_BIT = 564,
    parameter int unsigned NUM_BYTES    = 19200,
    parameter int unsigned ADDR_W       = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        fsm_state,
    input  logic [7:0]        bram_dout,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0]        SendToPc = 3'b101;
    localparam int unsigned       BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0]  BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   ByteLast = (ADDR_W + 1)'(NUM_BYTES - 1);
    localparam logic [1:0]        HdrNone  = 2'd2;
`ifdef PC_SENDER_HEADER_EN
    localparam logic [1:0]        HdrFirst = 2'd0;
`else
    localparam logic [1:0]        HdrFirst = HdrNone;
`endif

    typedef enum logic [2:0] {
        StIdle, StFetch, StWait, StStart, StData, StStop, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        prev_q;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [ADDR_W:0]   byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        shift_q, shift_d;
    logic              abort_q, abort_d;
    // 0: sending 0xA5, 1: sending 0x5A, 2: sending payload
    logic [1:0]        hdr_q, hdr_d;

    logic in_send, entry, baud_end;

    assign in_send  = (fsm_state == SendToPc);
    assign entry    = in_send && (prev_q != SendToPc);
    assign baud_end = (baud_q == BaudLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            prev_q  <= 3'b000;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            abort_q <= 1'b0;
            hdr_q   <= HdrNone;
        end else begin
            state_q <= state_d;
            prev_q  <= fsm_state;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            abort_q <= abort_d;
            hdr_q   <= hdr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        abort_d = abort_q;
        hdr_d   = hdr_q;

        unique case (state_q)
            StIdle: begin
                if (entry) begin
                    state_d = StFetch;
                    addr_d  = '0;
                    byte_d  = '0;
                    hdr_d   = HdrFirst;
                    abort_d = 1'b0;
                end
            end
            StFetch: state_d = in_send ? StWait : StIdle;
            StWait: begin
                if (!in_send) begin
                    state_d = StIdle;
                end else begin
                    case (hdr_q)
                        2'd0:    shift_d = 8'hA5;
                        2'd1:    shift_d = 8'h5A;
                        default: shift_d = bram_dout;
                    endcase
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                abort_d = abort_q | ~in_send;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                abort_d = abort_q | ~in_send;
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                abort_d = abort_q | ~in_send;
                if (baud_end) begin
                    baud_d = '0;
                    // An abort seen anywhere in the frame ends the transfer here
                    if (abort_q || !in_send) begin
                        state_d = StIdle;
                    end else if (hdr_q != HdrNone) begin
                        hdr_d   = hdr_q + 2'd1;
                        state_d = StFetch;
                    end else if (byte_q == ByteLast) begin
                        state_d = StDone;
                    end else begin
                        byte_d  = byte_q + (ADDR_W + 1)'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StFetch;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StDone: begin
                if (!in_send) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StFetch, StWait: busy = 1'b1;
            StStart: begin
                busy = 1'b1;
                tx   = 1'b0;
            end
            StData: begin
                busy = 1'b1;
                tx   = shift_q[0];
            end
            StStop:  busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign bram_addr = addr_q;

endmodule

// File: tb/tb_pc_sender.sv
// Directed bench for pc_sender: frame tables plus abort, reset and short-transfer sequences.
module tb_pc_sender;

    localparam int unsigned Cpb = 4;
    localparam int unsigned Aw  = 4;
`ifdef PC_SENDER_HEADER_EN
    localparam int Hdr = 2;
`else
    localparam int Hdr = 0;
`endif

    typedef struct {
        logic [7:0]    data;
        logic [Aw-1:0] addr;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    fsm0, fsm1;
    logic [7:0]    dout0, dout1;
    logic [Aw-1:0] addr0, addr1, addr_m;
    logic          tx0, tx1, busy0, busy1, done0, done1;
    logic          tx_m, busy_m, done_m;
    logic [7:0]    mem [0:3];
    int            sel;
    int            tests = 0;
    int            fails = 0;

    frame_t fr3 [5];
    frame_t fr1 [3];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        dout0 <= mem[addr0[1:0]];
        dout1 <= mem[addr1[1:0]];
    end

    always_comb begin
        if (sel == 1) begin
            tx_m = tx1; busy_m = busy1; done_m = done1; addr_m = addr1;
        end else begin
            tx_m = tx0; busy_m = busy0; done_m = done0; addr_m = addr0;
        end
    end

    pc_sender #(.CLKS_PER_BIT(Cpb), .NUM_BYTES(3), .ADDR_W(Aw)) u_dut (
        .clk(clk), .rst(rst), .fsm_state(fsm0), .bram_dout(dout0),
        .bram_addr(addr0), .tx(tx0), .busy(busy0), .done(done0)
    );

    pc_sender #(.CLKS_PER_BIT(Cpb), .NUM_BYTES(1), .ADDR_W(Aw)) u_dut1 (
        .clk(clk), .rst(rst), .fsm_state(fsm1), .bram_dout(dout1),
        .bram_addr(addr1), .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_low(output int gap);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_m === 1'b0) return;
            gap++;
        end
    endtask

    // Expects a 2-cycle idle gap, then one 40-cycle frame; can drop/raise fsm0 mid-frame.
    task automatic run_frame(input string tag, input frame_t f, input int drop_at,
                             input int raise_at);
        int          gap;
        int          bad_addr = 0;
        int          bad_busy = 0;
        logic [39:0] act, exp;
        wait_low(gap);
        check({tag, " gap"}, 64'(gap), 64'd2);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            act[i] = tx_m;
            if (addr_m !== f.addr) bad_addr++;
            if (busy_m !== 1'b1)   bad_busy++;
            if (i == drop_at)  fsm0 = 3'b000;
            if (i == raise_at) fsm0 = 3'b101;
            if (i < 4)       exp[i] = 1'b0;
            else if (i < 36) exp[i] = f.data[(i - 4) / 4];
            else             exp[i] = 1'b1;
        end
        check({tag, " frame"}, 64'(act), 64'(exp));
        check({tag, " addr"}, 64'(bad_addr), 64'd0);
        check({tag, " busy"}, 64'(bad_busy), 64'd0);
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, " done"}, 64'(done_m), 64'd1);
        check({tag, " busy_low"}, 64'(busy_m), 64'd0);
        check({tag, " tx_idle"}, 64'(tx_m), 64'd1);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
        end
        check({tag, " quiet"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int gap;
        int bad;
        mem[0] = 8'h55; mem[1] = 8'h0F; mem[2] = 8'hC3; mem[3] = 8'h00;
`ifdef PC_SENDER_HEADER_EN
        fr3[0] = '{8'hA5, 4'd0}; fr3[1] = '{8'h5A, 4'd0};
        fr3[2] = '{8'h55, 4'd0}; fr3[3] = '{8'h0F, 4'd1}; fr3[4] = '{8'hC3, 4'd2};
        fr1[0] = '{8'hA5, 4'd0}; fr1[1] = '{8'h5A, 4'd0}; fr1[2] = '{8'h55, 4'd0};
`else
        fr3[0] = '{8'h55, 4'd0}; fr3[1] = '{8'h0F, 4'd1}; fr3[2] = '{8'hC3, 4'd2};
        fr3[3] = '{8'h00, 4'd0}; fr3[4] = '{8'h00, 4'd0};
        fr1[0] = '{8'h55, 4'd0}; fr1[1] = '{8'h00, 4'd0}; fr1[2] = '{8'h00, 4'd0};
`endif
        sel  = 0;
        rst  = 1'b1;
        fsm0 = 3'b100;
        fsm1 = 3'b000;

        @(negedge clk);
        check("rst tx", 64'(tx0), 64'd1);
        check("rst busy", 64'(busy0), 64'd0);
        check("rst done", 64'(done0), 64'd0);
        check("rst addr", 64'(addr0), 64'd0);
        check("rst tx1", 64'(tx1), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full transfer from a 100 -> 101 entry edge
        fsm0 = 3'b101;
        for (int k = 0; k < 3 + Hdr; k++) run_frame("xfer", fr3[k], -1, -1);
        check_done("xfer");

        // Staying in SEND_TO_PC keeps done and never restarts
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done0 !== 1'b1 || busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
        end
        check("hold done", 64'(bad), 64'd0);
        fsm0 = 3'b000;
        @(negedge clk);
        check("leave done", 64'(done0), 64'd0);
        check_quiet("after leave", 20);

        // Drop out during bit 3 of payload byte 1: frame completes, no done
        fsm0 = 3'b101;
        for (int k = 0; k <= Hdr; k++) run_frame("abort pre", fr3[k], -1, -1);
        run_frame("abort", fr3[Hdr + 1], 18, -1);
        check_quiet("abort", 40);

        // Re-entry while the aborted byte finishes is ignored
        fsm0 = 3'b101;
        run_frame("reentry", fr3[0], 10, 30);
        check_quiet("reentry", 40);
        fsm0 = 3'b000;
        @(negedge clk);

        // Abort from FETCH returns to idle on the next edge
        fsm0 = 3'b101;
        @(negedge clk);
        check("fetch busy", 64'(busy0), 64'd1);
        check("fetch addr", 64'(addr0), 64'd0);
        fsm0 = 3'b000;
        @(negedge clk);
        check("fetch abort busy", 64'(busy0), 64'd0);
        check_quiet("fetch abort", 10);

        // Asynchronous reset in DATA of payload byte 1 (bit 5 of 0x0F is 0)
        fsm0 = 3'b101;
        for (int k = 0; k <= Hdr; k++) run_frame("rst pre", fr3[k], -1, -1);
        wait_low(gap);
        check("rst gap", 64'(gap), 64'd2);
        repeat (25) @(negedge clk);
        check("rst pre tx", 64'(tx0), 64'd0);
        check("rst pre addr", 64'(addr0), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async tx", 64'(tx0), 64'd1);
        check("async busy", 64'(busy0), 64'd0);
        check("async addr", 64'(addr0), 64'd0);
        check("async done", 64'(done0), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // fsm_state already 101 at reset release starts a transfer on the first edge
        for (int k = 0; k < 3 + Hdr; k++) run_frame("post rst", fr3[k], -1, -1);
        check_done("post rst");
        fsm0 = 3'b000;
        @(negedge clk);

        // NUM_BYTES = 1
        sel  = 1;
        fsm1 = 3'b101;
        for (int k = 0; k < 1 + Hdr; k++) run_frame("one", fr1[k], -1, -1);
        check_done("one");
        fsm1 = 3'b000;
        @(negedge clk);
        check("one leave", 64'(done1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sender.md
PC_SENDER -- requirements
Module: pc_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 564, clock cycles per UART bit (65 MHz / 115200 baud); legal values are 2 and above.
REQ-002 Parameter NUM_BYTES, default 19200, number of bytes read from BRAM and transmitted per transfer.
REQ-003 Parameter ADDR_W, default 15, BRAM address width; NUM_BYTES SHALL NOT exceed 2^ADDR_W.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 fsm_state  input  3  main FSM state; value 3'b101 is SEND_TO_PC.
REQ-007 bram_dout  input  8  BRAM read data, valid 1 cycle after bram_addr is presented.
REQ-008 bram_addr  output  ADDR_W  BRAM read address.
REQ-009 tx  output  1  UART serial line: 8N1, LSB first, idle high.
REQ-010 busy  output  1  high while a transfer is in progress.
REQ-011 done  output  1  high after a transfer completes, until fsm_state leaves 3'b101.

Function
REQ-012 A transfer SHALL start only on the first cycle where fsm_state==3'b101 and the previous cycle's sampled fsm_state!=3'b101 (entry edge); remaining in SEND_TO_PC SHALL NOT restart it.
REQ-013 States SHALL be IDLE, FETCH, WAIT, START, DATA, STOP and DONE.
REQ-014 IDLE->FETCH on entry edge; bram_addr SHALL be set to 0 and busy SHALL go high in the same cycle FETCH is entered.
REQ-015 FETCH->WAIT after 1 cycle; WAIT latches bram_dout into an 8-bit shift register, then moves to START (BRAM read latency of 1 cycle).
REQ-016 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles; DATA SHALL drive 8 bits LSB first, each for CLKS_PER_BIT cycles; STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-017 At the end of STOP: if the byte counter equals NUM_BYTES-1, go to DONE; otherwise increment bram_addr and go to FETCH. The inter-byte gap SHALL be exactly 2 cycles of tx=1 (FETCH and WAIT).
REQ-018 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap. The bit index SHALL count 0..7. The byte counter SHALL be ADDR_W+1 bits wide so that it never wraps at NUM_BYTES=2^ADDR_W.
REQ-019 DONE: busy=0, done=1, tx=1. DONE->IDLE when fsm_state!=3'b101.
REQ-020 Abort: if fsm_state leaves 3'b101 during FETCH or WAIT, go to IDLE at once. If it leaves during START, DATA or STOP, complete the current byte's STOP bit, then go to IDLE without setting done.
REQ-021 Re-entry into 3'b101 while a byte is finishing after an abort SHALL NOT be captured; only an entry edge seen in IDLE starts a transfer.

Reset
REQ-022 While rst is high: state=IDLE, tx=1, busy=0, done=0, bram_addr=0, all counters and the shift register cleared, and the sampled previous fsm_state cleared to 3'b000.
REQ-023 Reset asserted mid-byte SHALL force tx=1 immediately, with no attempt to complete framing.
REQ-024 After rst deasserts with fsm_state already at 3'b101, a transfer SHALL start on the first clock edge (the previous-state register holds 3'b000).

Configuration
REQ-025 Macro PC_SENDER_HEADER_EN. When defined, each transfer SHALL send header bytes 0xA5 then 0x5A before BRAM byte 0, using the same framing and 2-cycle gaps, with bram_addr held at 0 during the header. When undefined, no header is sent and payload starts immediately.
REQ-026 The header SHALL NOT count toward NUM_BYTES. Abort rules (REQ-020) apply to header bytes.

Verification (CLKS_PER_BIT=4, NUM_BYTES=3, BRAM holds 0x55,0x0F,0xC3; macro undefined unless stated)
REQ-027 Drive fsm_state 100->101 -> tx frames 0x55,0x0F,0xC3, each 40 cycles with 2-cycle gaps; bram_addr steps 0,1,2; done rises after the last stop bit; busy high throughout.
REQ-028 Hold 101 after done, then drop to 000 -> done falls the next cycle; no second transfer occurs.
REQ-029 Drop fsm_state to 000 during bit 3 of byte 1 -> byte 0x0F completes its stop bit, tx stays high, done stays 0, state is IDLE.
REQ-030 Assert rst during the DATA state of byte 0 -> tx=1, busy=0, bram_addr=0 asynchronously (before the next clock edge).
REQ-031 With PC_SENDER_HEADER_EN defined, drive entry edge -> tx frames 0xA5,0x5A,0x55,0x0F,0xC3, then done.
REQ-032 Set NUM_BYTES=1 -> a single frame 0x55 is sent, then DONE; bram_addr stays 0.
